// File: rtl/messbauer_diff_discriminator_counter_pkg.sv
// Shared pulse-FSM state codes and default sizing for the discriminator counter and its benches.
// Pure declarations: no logic, no latency, no flow control.
package messbauer_diff_discriminator_counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_LOWER_HIGH = 2'd1,
        ST_STUCK      = 2'd2
    } pulse_state_e;

    localparam int DEF_NUM_CHANNELS    = 512;
    localparam int DEF_CHANNEL_WIDTH   = 9;
    localparam int DEF_COUNT_WIDTH     = 16;
    localparam int DEF_MIN_LOWER_WIDTH = 2;
    localparam int DEF_MAX_LOWER_WIDTH = 64;

endpackage

// File: rtl/messbauer_signal_synchronizer.sv
// 2-FF synchronizer plus registered rise/fall flags; flags and level appear 3 aclk cycles after the pin.
// No flow control: flags are single-cycle pulses the consumer must take when they occur.
module messbauer_signal_synchronizer (
    input  logic aclk,
    input  logic areset_n,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;
    logic rise_q, rise_d;
    logic fall_q, fall_d;

    always_comb begin
        meta_d = async_in;
        sync_d = meta_q;
        prev_d = sync_q;
        rise_d = sync_q & ~prev_q;
        fall_d = ~sync_q & prev_q;
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    // prev_q is the synchronized level delayed to line up with the edge flags
    assign level = prev_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/messbauer_diff_discriminator_counter.sv
// Classifies lower-threshold pulses as accepted/rejected, counts them per channel and emits one result per channel strobe.
// Result appears 1 cycle after the synchronized channel rise; a close while the result is still unconsumed overwrites it and sets overrun.
module messbauer_diff_discriminator_counter
    import messbauer_diff_discriminator_counter_pkg::*;
#(
    parameter int NUM_CHANNELS    = DEF_NUM_CHANNELS,
    parameter int CHANNEL_WIDTH   = DEF_CHANNEL_WIDTH,
    parameter int COUNT_WIDTH     = DEF_COUNT_WIDTH,
    parameter int MIN_LOWER_WIDTH = DEF_MIN_LOWER_WIDTH,
    parameter int MAX_LOWER_WIDTH = DEF_MAX_LOWER_WIDTH
) (
    input  logic                     aclk,
    input  logic                     areset_n,
    input  logic                     lower_threshold,
    input  logic                     upper_threshold,
    input  logic                     channel,
    output logic                     result_valid,
    input  logic                     result_ready,
    output logic [CHANNEL_WIDTH-1:0] channel_index,
    output logic [COUNT_WIDTH-1:0]   accepted_count,
    output logic [COUNT_WIDTH-1:0]   rejected_count,
    output logic                     overrun,
    output logic                     stuck_error
);

    localparam int WW = $clog2(MAX_LOWER_WIDTH + 1);

    logic lower_rise, lower_fall, upper_lvl, upper_rise, chan_rise;
    logic unused_lower_lvl, unused_upper_fall, unused_chan_lvl, unused_chan_fall;

    messbauer_signal_synchronizer u_sync_lower (
        .aclk(aclk), .areset_n(areset_n), .async_in(lower_threshold),
        .level(unused_lower_lvl), .rise(lower_rise), .fall(lower_fall)
    );

    messbauer_signal_synchronizer u_sync_upper (
        .aclk(aclk), .areset_n(areset_n), .async_in(upper_threshold),
        .level(upper_lvl), .rise(upper_rise), .fall(unused_upper_fall)
    );

    messbauer_signal_synchronizer u_sync_channel (
        .aclk(aclk), .areset_n(areset_n), .async_in(channel),
        .level(unused_chan_lvl), .rise(chan_rise), .fall(unused_chan_fall)
    );

    pulse_state_e            state_q, state_d;
    logic [WW-1:0]           width_q, width_d;
    logic                    seen_q, seen_d;
    logic                    stuck_q, stuck_d;
    logic [WW-1:0]           width_inc;
    logic                    seen_now;
    logic                    inc_acc, inc_rej;

    logic [COUNT_WIDTH-1:0]   acc_q, acc_d, rej_q, rej_d;
    logic [COUNT_WIDTH-1:0]   acc_next, rej_next;
    logic [COUNT_WIDTH-1:0]   res_acc_q, res_acc_d, res_rej_q, res_rej_d;
    logic [CHANNEL_WIDTH-1:0] chan_cnt_q, chan_cnt_d, idx_q, idx_d;
    logic                     valid_q, valid_d;
    logic                     overrun_q, overrun_d;

    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v,
                                                       input logic inc);
        if (inc && (v != {COUNT_WIDTH{1'b1}}))
            return v + COUNT_WIDTH'(1);
        return v;
    endfunction

    // width_inc is the pulse length in cycles including the current one
    always_comb begin
        state_d   = state_q;
        width_d   = width_q;
        seen_d    = seen_q;
        stuck_d   = stuck_q;
        inc_acc   = 1'b0;
        inc_rej   = 1'b0;
        width_inc = width_q + WW'(1);
        seen_now  = seen_q | upper_lvl | upper_rise;
        case (state_q)
            ST_IDLE: begin
                if (lower_rise) begin
                    state_d = ST_LOWER_HIGH;
                    width_d = '0;
                    seen_d  = 1'b0;
                end
            end
            ST_LOWER_HIGH: begin
                width_d = width_inc;
                seen_d  = seen_now;
                if (lower_fall) begin
                    state_d = ST_IDLE;
                    if (width_inc >= WW'(MIN_LOWER_WIDTH)) begin
                        inc_acc = ~seen_now;
                        inc_rej = seen_now;
                    end
                end else if (width_inc >= WW'(MAX_LOWER_WIDTH)) begin
                    state_d = ST_STUCK;
                    stuck_d = 1'b1;
                end
            end
            ST_STUCK: begin
                if (lower_fall)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A classification landing on the close cycle belongs to the closing channel
    always_comb begin
        acc_next   = sat_inc(acc_q, inc_acc);
        rej_next   = sat_inc(rej_q, inc_rej);
        acc_d      = acc_next;
        rej_d      = rej_next;
        res_acc_d  = res_acc_q;
        res_rej_d  = res_rej_q;
        idx_d      = idx_q;
        chan_cnt_d = chan_cnt_q;
        overrun_d  = overrun_q;
        valid_d    = valid_q;
        if (valid_q && result_ready)
            valid_d = 1'b0;
        if (chan_rise) begin
            res_acc_d  = acc_next;
            res_rej_d  = rej_next;
            acc_d      = '0;
            rej_d      = '0;
            idx_d      = chan_cnt_q;
            chan_cnt_d = (chan_cnt_q == CHANNEL_WIDTH'(NUM_CHANNELS - 1)) ?
                         '0 : chan_cnt_q + CHANNEL_WIDTH'(1);
            valid_d    = 1'b1;
            if (valid_q && !result_ready)
                overrun_d = 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state_q    <= ST_IDLE;
            width_q    <= '0;
            seen_q     <= 1'b0;
            stuck_q    <= 1'b0;
            acc_q      <= '0;
            rej_q      <= '0;
            res_acc_q  <= '0;
            res_rej_q  <= '0;
            idx_q      <= '0;
            chan_cnt_q <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            width_q    <= width_d;
            seen_q     <= seen_d;
            stuck_q    <= stuck_d;
            acc_q      <= acc_d;
            rej_q      <= rej_d;
            res_acc_q  <= res_acc_d;
            res_rej_q  <= res_rej_d;
            idx_q      <= idx_d;
            chan_cnt_q <= chan_cnt_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
        end
    end

    assign result_valid   = valid_q;
    assign channel_index  = idx_q;
    assign accepted_count = res_acc_q;
    assign rejected_count = res_rej_q;
    assign overrun        = overrun_q;
    assign stuck_error    = stuck_q;

endmodule
